// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: repeat FSM states,
// scan candidate kinds and the code-width helper.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_e;

  // A KEY candidate carries its code in a separate field; NONE and GHOST carry code 0.
  typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_GHOST} cand_e;

  function automatic int code_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// First-word-fall-through code queue with occupancy and sticky overflow.
module keypad_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          clear_ovf,
  output logic          valid,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          empty, full, pop_ok, push_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign push_ok = push && (!full || pop_ok);
  assign valid   = !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level + LW'(push_ok) - LW'(pop_ok);
      overflow <= (push && !push_ok) || (overflow && !clear_ovf);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad front end: column scan, scan-level debounce with ghost
// rejection, auto-repeat FSM, and a FWFT queue of key codes.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 2500,
  parameter int DB_SCANS     = 4,
  parameter int REPEAT_DELAY = 100,
  parameter int REPEAT_RATE  = 20,
  parameter int FIFO_DEPTH   = 8,
  localparam int CW          = code_width(ROWS * COLS),
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_pop,
  output logic [LW-1:0]   fifo_level,
  output logic            overflow,
  input  logic            clear_ovf,
  output logic            held
);

  localparam int CIW  = code_width(COLS);
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int DBW  = $clog2(DB_SCANS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [ROWS-1:0]           row_meta, row_sync;
  logic                      drive_en;
  logic [CIW-1:0]            col_idx;
  logic [SW-1:0]             slot_cnt;
  logic [ROWS-1:0][COLS-1:0] snap, snap_now;
  logic                      slot_last, scan_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign slot_last = (slot_cnt == SW'(SCAN_DIV - 1));
  assign scan_end  = slot_last && (col_idx == CIW'(COLS - 1));
  assign col       = drive_en ? ~(COLS'(1) << col_idx) : '1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drive_en <= 1'b0;
      col_idx  <= '0;
      slot_cnt <= '0;
      snap     <= '0;
    end else begin
      drive_en <= 1'b1;
      slot_cnt <= slot_last ? '0 : slot_cnt + SW'(1);
      if (slot_last) col_idx <= scan_end ? '0 : col_idx + CIW'(1);
      snap <= snap_now;
    end
  end

  // Overlay the column being sampled so scan end sees the last column too.
  always_comb begin
    snap_now = snap;
    if (slot_last)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (CIW'(c) == col_idx) snap_now[r][c] = ~row_sync[r];
  end

  cand_e         cand_kind;
  logic [CW-1:0] cand_code;
  logic [1:0]    n_keys;

  always_comb begin
    n_keys    = '0;
    cand_code = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (snap_now[r][c]) begin
          if (n_keys != 2'd2) n_keys = n_keys + 2'd1;
          cand_code = CW'(r * COLS + c);
        end
    case (n_keys)
      2'd0:    cand_kind = CAND_NONE;
      2'd1:    cand_kind = CAND_KEY;
      default: begin cand_kind = CAND_GHOST; cand_code = '0; end
    endcase
  end

  cand_e          prev_kind, prev_kind_n, stable_kind, stable_kind_n;
  logic [CW-1:0]  prev_code, prev_code_n, stable_code, stable_code_n;
  logic [DBW-1:0] db_cnt, db_cnt_n;

  always_comb begin
    prev_kind_n   = prev_kind;
    prev_code_n   = prev_code;
    stable_kind_n = stable_kind;
    stable_code_n = stable_code;
    db_cnt_n      = db_cnt;
    if (scan_end && cand_kind != CAND_GHOST) begin
      if ({cand_kind, cand_code} == {prev_kind, prev_code}) begin
        if (db_cnt != DBW'(DB_SCANS)) db_cnt_n = db_cnt + DBW'(1);
      end else begin
        db_cnt_n    = DBW'(1);
        prev_kind_n = cand_kind;
        prev_code_n = cand_code;
      end
      if (db_cnt_n == DBW'(DB_SCANS) && {cand_kind, cand_code} != {stable_kind, stable_code}) begin
        stable_kind_n = cand_kind;
        stable_code_n = cand_code;
      end
    end
  end

  state_e        state, state_n;
  logic [RW-1:0] rep_cnt, rep_cnt_n, rep_inc;
  logic          push;

  assign rep_inc = rep_cnt + RW'(1);

  always_comb begin
    state_n   = state;
    rep_cnt_n = rep_cnt;
    push      = 1'b0;
    if (scan_end) begin
      if (stable_kind_n != CAND_KEY) begin
        state_n   = IDLE;
        rep_cnt_n = '0;
      end else if ({stable_kind_n, stable_code_n} != {stable_kind, stable_code}) begin
        push      = 1'b1;
        state_n   = PRESS;
        rep_cnt_n = '0;
      end else begin
        case (state)
          PRESS:
            if (REPEAT_DELAY != 0) begin
              if (rep_inc == RW'(REPEAT_DELAY)) begin
                push      = 1'b1;
                state_n   = REPEAT;
                rep_cnt_n = '0;
              end else rep_cnt_n = rep_inc;
            end
          REPEAT:
            if (rep_inc == RW'(REPEAT_RATE)) begin
              push      = 1'b1;
              rep_cnt_n = '0;
            end else rep_cnt_n = rep_inc;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_kind   <= CAND_NONE;
      prev_code   <= '0;
      stable_kind <= CAND_NONE;
      stable_code <= '0;
      db_cnt      <= '0;
      state       <= IDLE;
      rep_cnt     <= '0;
    end else begin
      prev_kind   <= prev_kind_n;
      prev_code   <= prev_code_n;
      stable_kind <= stable_kind_n;
      stable_code <= stable_code_n;
      db_cnt      <= db_cnt_n;
      state       <= state_n;
      rep_cnt     <= rep_cnt_n;
    end
  end

  assign held = (state != IDLE);

  keypad_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .din       (stable_code_n),
    .pop       (key_pop),
    .clear_ovf (clear_ovf),
    .valid     (key_valid),
    .dout      (key_code),
    .level     (fifo_level),
    .overflow  (overflow)
  );

endmodule

// File: doc/keypad_scan_fifo.md
# keypad_scan_fifo

Parametrised keypad front end: scans an R×C matrix, debounces at scan granularity, rejects multi-key (ghost) patterns, generates auto-repeat and queues key codes in a first-word-fall-through FIFO. Replaces the fixed 4×4 scanner + debouncer + edge-strobe chain feeding the calculator input handler. The consumer pops codes at its own pace, so keystrokes are never lost between FSM states.

## Interface
- ROWS, 4, matrix rows (≥1)
- COLS, 4, matrix columns (≥2)
- SCAN_DIV, 2500, clock cycles each column is driven (≥4)
- DB_SCANS, 4, consecutive identical scans required to accept a change (≥1)
- REPEAT_DELAY, 100, scans before first auto-repeat; 0 disables repeat
- REPEAT_RATE, 20, scans between subsequent repeats (≥1)
- FIFO_DEPTH, 8, queued codes (power of 2, ≥2)
- CW, derived = $clog2(ROWS*COLS), code width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- row  in  ROWS  matrix rows, active-low (pulled up), asynchronous
- col  out  COLS  column drive, active-low one-hot
- key_valid  out  1  FIFO head holds a code
- key_code  out  CW  code at FIFO head, = row_index*COLS + col_index
- key_pop  in  1  consume head; ignored when key_valid=0
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky: a code was dropped
- clear_ovf  in  1  clears overflow
- held  out  1  a debounced key is currently down

## Operation
- row passes through a 2-flop synchroniser before use.
- Scanner: column index c cycles 0..COLS-1; col = ~(1<<c). Slot counter counts SCAN_DIV cycles; rows sampled on the last cycle of each slot into a ROWS×COLS snapshot.
- Scan evaluation on the last cycle of column COLS-1 ("scan end"). Candidate: 0 keys → NONE; exactly 1 key → its code; ≥2 keys → GHOST.
- Debounce: GHOST never advances or resets the counter and never changes the stable state. Otherwise candidate equal to previous candidate increments match count (saturating at DB_SCANS); different candidate sets count to 1. When count reaches DB_SCANS and candidate ≠ stable, stable ← candidate.
- FSM states IDLE, PRESS, REPEAT. IDLE→PRESS on stable becoming a key: push code, repeat counter ← 0. PRESS→REPEAT when counter reaches REPEAT_DELAY (push code). REPEAT: push every REPEAT_RATE scans. Any state → IDLE on stable NONE (no push). Direct key-to-key stable change: push new code, re-enter PRESS.
- held = state ≠ IDLE.
- FIFO: push when full and no pop in same cycle → code dropped, overflow ← 1. Push + pop same cycle when full: both succeed, level unchanged, no overflow. Push + pop when empty: push wins, key_valid=1 next cycle. clear_ovf and a simultaneous drop: overflow stays 1.
- Reset (any time, incl. mid-scan or mid-debounce): col='1 (nothing driven), c=0, slot counter=0, snapshot/candidate/stable=NONE, state IDLE, FIFO empty, key_valid=0, key_code=0, fifo_level=0, overflow=0, held=0. col drives ~1 from the first clock after reset deasserts.

## Timing
- Scan period P = COLS*SCAN_DIV cycles.
- Press recognised at scan end of the DB_SCANS-th consecutive matching scan; push in that cycle; key_valid and key_code visible the following cycle.
- Worst-case press-to-valid: (DB_SCANS+1)*P + 3 cycles (sync + push).
- key_pop: head advances one cycle later; next code (if any) visible then; back-to-back pops every cycle allowed.
- First repeat REPEAT_DELAY scans after the initial push, then every REPEAT_RATE scans.

## Structure
- Package keypad_pkg: state enum (IDLE, PRESS, REPEAT), NONE/GHOST candidate encoding, code-width function.
- Sub-module keypad_fifo (FWFT, parametrised width/depth, level and overflow) instantiated once; scanner, debounce and repeat FSM in the top.

## Test plan
- ROWS=COLS=4, SCAN_DIV=4, DB_SCANS=3: hold row 2/col 1 clean → exactly one code 9 after ≤ 4P+3 cycles; release → no push, held falls.
- Bounce toggling every 1.5 scans for 10 scans, then stable key 5 → no code during bounce, single code 5 after stabilising.
- Press keys 0 and 5 simultaneously → no code; release 5 → code 0 after DB_SCANS scans.
- REPEAT_DELAY=10, REPEAT_RATE=3, hold key 15 for 25 scans → codes at scans 0, 10, 13, 16, 19, 22 (6 entries).
- FIFO_DEPTH=4, no pops, 6 distinct presses → level=4, first four codes retained, overflow=1; clear_ovf → 0; pop on full with simultaneous push → level stays 4.
- Assert reset mid-debounce with 2 codes queued → all outputs at reset values, col='1; after release, scanning restarts at column 0.
